// File: rtl/axi_modport_slave.sv
// AXI4 slave endpoint backed by a word-addressed RAM; independent write and read FSMs.
// Latency: BVALID one cycle after the last W beat, first RVALID one cycle after the AR handshake.
// Backpressure: B and R outputs are registered and held stable while BREADY/RREADY is low.
module axi_modport_slave #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [ID_W-1:0]     S1_AWID,
    input  logic [ADDR_W-1:0]   S1_AWADDR,
    input  logic [3:0]          S1_AWLEN,
    input  logic [2:0]          S1_AWSIZE,
    input  logic [1:0]          S1_AWBURST,
    input  logic                S1_AWLOCK,
    input  logic [3:0]          S1_AWCACHE,
    input  logic [2:0]          S1_AWPROT,
    input  logic [3:0]          S1_AWQOS,
    input  logic [3:0]          S1_AWREGION,
    input  logic [0:0]          S1_AWUSER,
    input  logic                S1_AWVALID,
    output logic                S1_AWREADY,
    input  logic [DATA_W-1:0]   S1_WDATA,
    input  logic [DATA_W/8-1:0] S1_WSTRB,
    input  logic                S1_WLAST,
    input  logic [0:0]          S1_WUSER,
    input  logic                S1_WVALID,
    output logic                S1_WREADY,
    output logic [ID_W-1:0]     S1_BID,
    output logic [1:0]          S1_BRESP,
    output logic [0:0]          S1_BUSER,
    output logic                S1_BVALID,
    input  logic                S1_BREADY,
    input  logic [ID_W-1:0]     S1_ARID,
    input  logic [ADDR_W-1:0]   S1_ARADDR,
    input  logic [3:0]          S1_ARLEN,
    input  logic [2:0]          S1_ARSIZE,
    input  logic [1:0]          S1_ARBURST,
    input  logic                S1_ARLOCK,
    input  logic [3:0]          S1_ARCACHE,
    input  logic [2:0]          S1_ARPROT,
    input  logic [3:0]          S1_ARQOS,
    input  logic [3:0]          S1_ARREGION,
    input  logic [0:0]          S1_ARUSER,
    input  logic                S1_ARVALID,
    output logic                S1_ARREADY,
    output logic [ID_W-1:0]     S1_RID,
    output logic [DATA_W-1:0]   S1_RDATA,
    output logic [1:0]          S1_RRESP,
    output logic                S1_RLAST,
    output logic [0:0]          S1_RUSER,
    output logic                S1_RVALID,
    input  logic                S1_RREADY
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH * STRB_W);
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return a < LIMIT;
    endfunction

    // WRAP keeps the beat inside the (LEN+1)*step aligned window.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic [2:0] size,
                                                    input logic [1:0] burst, input logic [3:0] len);
        logic [ADDR_W-1:0] step, mask;
        step = ADDR_W'(1) << size;
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        case (burst)
            2'b00:   return a;
            2'b10:   return (a & ~mask) | ((a + step) & mask);
            default: return a + step;
        endcase
    endfunction

    logic unused_sideband;
    assign unused_sideband = ^{S1_AWLOCK, S1_AWCACHE, S1_AWPROT, S1_AWQOS, S1_AWREGION, S1_AWUSER,
                               S1_ARLOCK, S1_ARCACHE, S1_ARPROT, S1_ARQOS, S1_ARREGION, S1_ARUSER, S1_WUSER};

    w_state_e          w_state_q, w_state_d;
    logic [ID_W-1:0]   w_id_q, w_id_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [3:0]        w_len_q, w_len_d, w_beat_q, w_beat_d;
    logic [2:0]        w_size_q, w_size_d;
    logic [1:0]        w_burst_q, w_burst_d;
    logic              w_err_q, w_err_d;
    logic              w_fire, w_at_len;

    assign w_fire   = (w_state_q == W_DATA) && S1_WVALID;
    assign w_at_len = (w_beat_q == w_len_q);

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_size_d  = w_size_q;
        w_burst_d = w_burst_q;
        w_beat_d  = w_beat_q;
        w_err_d   = w_err_q;
        case (w_state_q)
            W_IDLE: if (S1_AWVALID) begin
                w_id_d    = S1_AWID;
                w_addr_d  = S1_AWADDR;
                w_len_d   = S1_AWLEN;
                w_size_d  = S1_AWSIZE;
                w_burst_d = S1_AWBURST;
                w_beat_d  = 4'd0;
                w_err_d   = (S1_AWBURST == 2'b11);
                w_state_d = W_DATA;
            end
            W_DATA: if (S1_WVALID) begin
                w_addr_d = next_addr(w_addr_q, w_size_q, w_burst_q, w_len_q);
                w_beat_d = w_beat_q + 4'd1;
                // Early or missing WLAST both terminate the burst as an error.
                if (!in_range(w_addr_q) || (S1_WLAST != w_at_len)) w_err_d = 1'b1;
                if (S1_WLAST || w_at_len) w_state_d = W_RESP;
            end
            W_RESP: if (S1_BREADY) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_beat_q  <= '0;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_beat_q  <= w_beat_d;
            w_err_q   <= w_err_d;
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_fire && in_range(w_addr_q)) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (S1_WSTRB[b]) mem[w_addr_q[OFF_W +: IDX_W]][8*b +: 8] <= S1_WDATA[8*b +: 8];
            end
        end
    end

    assign S1_AWREADY = (w_state_q == W_IDLE) && !ARESET;
    assign S1_WREADY  = (w_state_q == W_DATA);
    assign S1_BVALID  = (w_state_q == W_RESP);
    assign S1_BID     = w_id_q;
    assign S1_BRESP   = w_err_q ? SLVERR : OKAY;
    assign S1_BUSER   = 1'b0;

    r_state_e          r_state_q, r_state_d;
    logic [ID_W-1:0]   r_id_q, r_id_d;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d, r_load_addr;
    logic [3:0]        r_len_q, r_len_d, r_beat_q, r_beat_d;
    logic [2:0]        r_size_q, r_size_d;
    logic [1:0]        r_burst_q, r_burst_d, r_load_burst, r_resp_q, r_resp_d, r_load_resp;
    logic [DATA_W-1:0] r_data_q, r_data_d, r_load_dat;
    logic              r_load_ok;

    // The RAM is sampled into r_data_q, so a same-cycle write to the word is seen as old data.
    always_comb begin
        r_load_addr  = (r_state_q == R_IDLE) ? S1_ARADDR : next_addr(r_addr_q, r_size_q, r_burst_q, r_len_q);
        r_load_burst = (r_state_q == R_IDLE) ? S1_ARBURST : r_burst_q;
        r_load_ok    = in_range(r_load_addr);
        r_load_dat   = r_load_ok ? mem[r_load_addr[OFF_W +: IDX_W]] : '0;
        r_load_resp  = (!r_load_ok || r_load_burst == 2'b11) ? SLVERR : OKAY;
    end

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_beat_d  = r_beat_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;
        case (r_state_q)
            R_IDLE: if (S1_ARVALID) begin
                r_id_d    = S1_ARID;
                r_addr_d  = S1_ARADDR;
                r_len_d   = S1_ARLEN;
                r_size_d  = S1_ARSIZE;
                r_burst_d = S1_ARBURST;
                r_beat_d  = 4'd0;
                r_data_d  = r_load_dat;
                r_resp_d  = r_load_resp;
                r_state_d = R_DATA;
            end
            R_DATA: if (S1_RREADY) begin
                if (r_beat_q == r_len_q) begin
                    r_state_d = R_IDLE;
                end else begin
                    r_addr_d = r_load_addr;
                    r_beat_d = r_beat_q + 4'd1;
                    r_data_d = r_load_dat;
                    r_resp_d = r_load_resp;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_beat_q  <= '0;
            r_data_q  <= '0;
            r_resp_q  <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_beat_q  <= r_beat_d;
            r_data_q  <= r_data_d;
            r_resp_q  <= r_resp_d;
        end
    end

    assign S1_ARREADY = (r_state_q == R_IDLE) && !ARESET;
    assign S1_RVALID  = (r_state_q == R_DATA);
    assign S1_RLAST   = (r_state_q == R_DATA) && (r_beat_q == r_len_q);
    assign S1_RID     = r_id_q;
    assign S1_RDATA   = r_data_q;
    assign S1_RRESP   = r_resp_q;
    assign S1_RUSER   = 1'b0;
endmodule

// File: tb/tb_axi_modport_slave.sv
// Scoreboard bench for axi_modport_slave: drivers push expected B/R responses, monitors pop and compare.
`timescale 1ns/1ps
module tb_axi_modport_slave;
    localparam int ID_W = 4, ADDR_W = 32, DATA_W = 32, DEPTH = 256;
    localparam int LIMIT = DEPTH * 4;

    logic ACLK, ARESET;
    logic [ID_W-1:0] S1_AWID, S1_ARID, S1_BID, S1_RID;
    logic [ADDR_W-1:0] S1_AWADDR, S1_ARADDR;
    logic [3:0] S1_AWLEN, S1_ARLEN, S1_AWCACHE, S1_ARCACHE, S1_AWQOS, S1_ARQOS, S1_AWREGION, S1_ARREGION;
    logic [2:0] S1_AWSIZE, S1_ARSIZE, S1_AWPROT, S1_ARPROT;
    logic [1:0] S1_AWBURST, S1_ARBURST, S1_BRESP, S1_RRESP;
    logic S1_AWLOCK, S1_ARLOCK, S1_AWVALID, S1_AWREADY, S1_ARVALID, S1_ARREADY;
    logic [0:0] S1_AWUSER, S1_ARUSER, S1_WUSER, S1_BUSER, S1_RUSER;
    logic [DATA_W-1:0] S1_WDATA, S1_RDATA;
    logic [3:0] S1_WSTRB;
    logic S1_WLAST, S1_WVALID, S1_WREADY, S1_BVALID, S1_BREADY, S1_RLAST, S1_RVALID, S1_RREADY;

    axi_modport_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S1_AWID(S1_AWID), .S1_AWADDR(S1_AWADDR), .S1_AWLEN(S1_AWLEN), .S1_AWSIZE(S1_AWSIZE),
        .S1_AWBURST(S1_AWBURST), .S1_AWLOCK(S1_AWLOCK), .S1_AWCACHE(S1_AWCACHE), .S1_AWPROT(S1_AWPROT),
        .S1_AWQOS(S1_AWQOS), .S1_AWREGION(S1_AWREGION), .S1_AWUSER(S1_AWUSER),
        .S1_AWVALID(S1_AWVALID), .S1_AWREADY(S1_AWREADY),
        .S1_WDATA(S1_WDATA), .S1_WSTRB(S1_WSTRB), .S1_WLAST(S1_WLAST), .S1_WUSER(S1_WUSER),
        .S1_WVALID(S1_WVALID), .S1_WREADY(S1_WREADY),
        .S1_BID(S1_BID), .S1_BRESP(S1_BRESP), .S1_BUSER(S1_BUSER), .S1_BVALID(S1_BVALID), .S1_BREADY(S1_BREADY),
        .S1_ARID(S1_ARID), .S1_ARADDR(S1_ARADDR), .S1_ARLEN(S1_ARLEN), .S1_ARSIZE(S1_ARSIZE),
        .S1_ARBURST(S1_ARBURST), .S1_ARLOCK(S1_ARLOCK), .S1_ARCACHE(S1_ARCACHE), .S1_ARPROT(S1_ARPROT),
        .S1_ARQOS(S1_ARQOS), .S1_ARREGION(S1_ARREGION), .S1_ARUSER(S1_ARUSER),
        .S1_ARVALID(S1_ARVALID), .S1_ARREADY(S1_ARREADY),
        .S1_RID(S1_RID), .S1_RDATA(S1_RDATA), .S1_RRESP(S1_RRESP), .S1_RLAST(S1_RLAST),
        .S1_RUSER(S1_RUSER), .S1_RVALID(S1_RVALID), .S1_RREADY(S1_RREADY)
    );

    typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;
    b_exp_t exp_b[$];
    r_exp_t exp_r[$];
    logic [31:0] model_mem [DEPTH];
    logic [31:0] wbuf [16];
    int n_checks = 0, n_fail = 0;
    bit rr_rand = 0;

    initial begin
        ACLK = 0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference address sequence with SIZE fixed at 4 bytes.
    function automatic logic [31:0] bnext(input logic [31:0] a, input logic [1:0] burst, input logic [3:0] len);
        int unsigned bnd, lo;
        case (burst)
            2'b00: return a;
            2'b10: begin
                bnd = (int'(len) + 1) * 4;
                lo  = (a / bnd) * bnd;
                return (a + 4 >= lo + bnd) ? lo : a + 4;
            end
            default: return a + 4;
        endcase
    endfunction

    initial begin : b_mon
        b_exp_t e;
        forever begin
            @(negedge ACLK);
            if (!ARESET && S1_BVALID && S1_BREADY) begin
                if (exp_b.size() == 0) check_val("b_unexpected", S1_BVALID, 0);
                else begin
                    e = exp_b.pop_front();
                    check_val("b_id", S1_BID, e.id);
                    check_val("b_resp", S1_BRESP, e.resp);
                    check_val("b_user", S1_BUSER, 0);
                end
            end
        end
    end

    initial begin : r_mon
        r_exp_t e;
        logic hold;
        logic [36:0] prev;
        hold = 0;
        prev = '0;
        forever begin
            @(negedge ACLK);
            if (!ARESET) begin
                if (hold) check_val("r_hold", {S1_RVALID, S1_RRESP, S1_RLAST, S1_RDATA}, prev);
                hold = S1_RVALID && !S1_RREADY;
                prev = {S1_RVALID, S1_RRESP, S1_RLAST, S1_RDATA};
                if (S1_RVALID && S1_RREADY) begin
                    if (exp_r.size() == 0) check_val("r_unexpected", S1_RVALID, 0);
                    else begin
                        e = exp_r.pop_front();
                        check_val("r_id", S1_RID, e.id);
                        check_val("r_data", S1_RDATA, e.data);
                        check_val("r_resp", S1_RRESP, e.resp);
                        check_val("r_last", S1_RLAST, e.last);
                        check_val("r_user", S1_RUSER, 0);
                    end
                end
            end else hold = 0;
        end
    end

    initial begin : rready_drv
        S1_RREADY = 1;
        forever begin
            @(posedge ACLK);
            #1;
            S1_RREADY = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input int last_at, input logic [3:0] strb);
        logic [31:0] a;
        int nb, n;
        bit err;
        b_exp_t e;
        nb  = (last_at <= int'(len)) ? last_at + 1 : int'(len) + 1;
        err = (burst == 2'b11) || (last_at != int'(len));
        S1_AWID = id; S1_AWADDR = addr; S1_AWLEN = len; S1_AWSIZE = 3'd2; S1_AWBURST = burst; S1_AWVALID = 1;
        n = 0;
        @(negedge ACLK);
        while (!S1_AWREADY && n < 50) begin @(negedge ACLK); n++; end
        if (n >= 50) check_val("aw_timeout", n, 0);
        @(posedge ACLK); #1;
        S1_AWVALID = 0;
        a = addr;
        for (int i = 0; i < nb; i++) begin
            S1_WDATA = wbuf[i]; S1_WSTRB = strb; S1_WLAST = (i == last_at); S1_WVALID = 1;
            if (a < LIMIT) begin
                for (int b = 0; b < 4; b++) if (strb[b]) model_mem[a >> 2][8*b +: 8] = wbuf[i][8*b +: 8];
            end else err = 1;
            n = 0;
            @(negedge ACLK);
            while (!S1_WREADY && n < 50) begin @(negedge ACLK); n++; end
            if (n >= 50) check_val("w_timeout", n, 0);
            @(posedge ACLK); #1;
            S1_WVALID = 0; S1_WLAST = 0;
            a = bnext(a, burst, len);
        end
        e.id = id;
        e.resp = err ? 2'b10 : 2'b00;
        exp_b.push_back(e);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst);
        logic [31:0] a;
        int n;
        r_exp_t e;
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            e.id   = id;
            e.data = (a < LIMIT) ? model_mem[a >> 2] : 32'h0;
            e.resp = (a >= LIMIT || burst == 2'b11) ? 2'b10 : 2'b00;
            e.last = (i == int'(len));
            exp_r.push_back(e);
            a = bnext(a, burst, len);
        end
        S1_ARID = id; S1_ARADDR = addr; S1_ARLEN = len; S1_ARSIZE = 3'd2; S1_ARBURST = burst; S1_ARVALID = 1;
        n = 0;
        @(negedge ACLK);
        while (!S1_ARREADY && n < 50) begin @(negedge ACLK); n++; end
        if (n >= 50) check_val("ar_timeout", n, 0);
        @(posedge ACLK); #1;
        S1_ARVALID = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_b.size() + exp_r.size()) != 0 && n < 400) begin @(negedge ACLK); n++; end
        check_val("drain", exp_b.size() + exp_r.size(), 0);
        @(posedge ACLK); #1;
    endtask

    initial begin : main
        int n;
        ARESET = 1;
        S1_AWID = 0; S1_AWADDR = 0; S1_AWLEN = 0; S1_AWSIZE = 0; S1_AWBURST = 0; S1_AWVALID = 0;
        S1_AWLOCK = 0; S1_AWCACHE = 0; S1_AWPROT = 0; S1_AWQOS = 0; S1_AWREGION = 0; S1_AWUSER = 0;
        S1_ARID = 0; S1_ARADDR = 0; S1_ARLEN = 0; S1_ARSIZE = 0; S1_ARBURST = 0; S1_ARVALID = 0;
        S1_ARLOCK = 0; S1_ARCACHE = 0; S1_ARPROT = 0; S1_ARQOS = 0; S1_ARREGION = 0; S1_ARUSER = 0;
        S1_WDATA = 0; S1_WSTRB = 0; S1_WLAST = 0; S1_WUSER = 0; S1_WVALID = 0; S1_BREADY = 1;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;

        repeat (2) @(negedge ACLK);
        check_val("rst_awready", S1_AWREADY, 0);
        check_val("rst_arready", S1_ARREADY, 0);
        check_val("rst_wready", S1_WREADY, 0);
        check_val("rst_bvalid", S1_BVALID, 0);
        check_val("rst_rvalid", S1_RVALID, 0);
        check_val("rst_rlast", S1_RLAST, 0);
        check_val("rst_outs", {S1_BID, S1_BRESP, S1_RID, S1_RDATA, S1_RRESP}, 0);
        @(posedge ACLK); #1;
        ARESET = 0;
        @(negedge ACLK);
        check_val("post_rst_awready", S1_AWREADY, 1);
        check_val("post_rst_arready", S1_ARREADY, 1);
        @(posedge ACLK); #1;

        wbuf[0] = 32'hA5A5_1234;
        do_write(4'd3, 32'h10, 4'd0, 2'b01, 0, 4'hF);
        drain();
        do_read(4'd5, 32'h10, 4'd0, 2'b01);
        drain();

        for (int i = 0; i < 4; i++) wbuf[i] = i + 1;
        do_write(4'd1, 32'h40, 4'd3, 2'b01, 3, 4'hF);
        drain();
        rr_rand = 1;
        do_read(4'd2, 32'h40, 4'd3, 2'b01);
        drain();
        rr_rand = 0;

        S1_AWLOCK = 1;
        wbuf[0] = 32'hFFFF_FFFF;
        do_write(4'd4, 32'h0, 4'd0, 2'b01, 0, 4'hF);
        wbuf[0] = 32'h0;
        do_write(4'd4, 32'h0, 4'd0, 2'b01, 0, 4'h3);
        drain();
        S1_AWLOCK = 0;
        do_read(4'd6, 32'h0, 4'd0, 2'b01);
        drain();

        S1_BREADY = 0;
        wbuf[0] = 32'h1357_9BDF;
        do_write(4'd9, 32'h20, 4'd0, 2'b01, 0, 4'hF);
        n = 0;
        @(negedge ACLK);
        while (!S1_BVALID && n < 50) begin @(negedge ACLK); n++; end
        for (int i = 0; i < 5; i++) begin
            check_val("bp_bvalid", S1_BVALID, 1);
            check_val("bp_bid", S1_BID, 9);
            check_val("bp_bresp", S1_BRESP, 0);
            @(negedge ACLK);
        end
        @(posedge ACLK); #1;
        S1_BREADY = 1;
        drain();

        wbuf[0] = 32'hDEAD_BEEF;
        do_write(4'd7, LIMIT, 4'd0, 2'b01, 0, 4'hF);
        do_read(4'd7, LIMIT, 4'd0, 2'b01);
        drain();
        wbuf[0] = 32'h0BAD_CAFE; wbuf[1] = 32'h0BAD_F00D;
        do_write(4'd8, LIMIT - 4, 4'd1, 2'b01, 1, 4'hF);
        do_read(4'd8, LIMIT - 4, 4'd1, 2'b01);
        do_read(4'd2, 32'h40, 4'd3, 2'b01);
        drain();

        for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0DE_0000 + i;
        do_write(4'd10, 32'h88, 4'd3, 2'b10, 3, 4'hF);
        do_read(4'd10, 32'h80, 4'd3, 2'b01);
        do_read(4'd11, 32'h88, 4'd3, 2'b10);
        drain();

        wbuf[0] = 32'h11; wbuf[1] = 32'h22;
        do_write(4'd12, 32'h60, 4'd1, 2'b11, 1, 4'hF);
        do_read(4'd12, 32'h60, 4'd1, 2'b01);
        do_read(4'd13, 32'h60, 4'd1, 2'b11);
        wbuf[0] = 32'h33; wbuf[1] = 32'h44;
        do_write(4'd14, 32'hC0, 4'd3, 2'b01, 1, 4'hF);
        do_write(4'd15, 32'hD0, 4'd1, 2'b01, 99, 4'hF);
        do_read(4'd14, 32'hC0, 4'd1, 2'b00);
        drain();

        S1_AWID = 4'd5; S1_AWADDR = 32'h100; S1_AWLEN = 4'd3; S1_AWSIZE = 3'd2; S1_AWBURST = 2'b01; S1_AWVALID = 1;
        @(negedge ACLK);
        @(posedge ACLK); #1;
        S1_AWVALID = 0;
        S1_WDATA = 32'h5555; S1_WSTRB = 4'hF; S1_WVALID = 1;
        @(posedge ACLK); #1;
        S1_WDATA = 32'h6666;
        #1 ARESET = 1;
        #1;
        check_val("mid_rst_awready", S1_AWREADY, 0);
        check_val("mid_rst_wready", S1_WREADY, 0);
        check_val("mid_rst_bvalid", S1_BVALID, 0);
        check_val("mid_rst_arready", S1_ARREADY, 0);
        check_val("mid_rst_rvalid", S1_RVALID, 0);
        @(posedge ACLK); #1;
        S1_WVALID = 0;
        @(posedge ACLK); #1;
        ARESET = 0;
        @(negedge ACLK);
        check_val("mid_rst_release_awready", S1_AWREADY, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge ACLK);
            check_val("mid_rst_no_bvalid", S1_BVALID, 0);
        end
        @(posedge ACLK); #1;
        do_read(4'd1, 32'h10, 4'd0, 2'b01);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
